// File: rtl/rpt_event_logger.sv
// Multi-channel event logger: round-robin intake, severity filter,
// log FIFO, saturating per-type statistics and stop/exit halting.
module rpt_event_logger #(
   parameter int NUM_CH = 4,
   parameter int MSG_W  = 16,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 16,
   parameter int TS_W   = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_CH-1:0]       ev_valid_i,
   output logic [NUM_CH-1:0]       ev_ready_o,
   input  logic [2*NUM_CH-1:0]     ev_type_i,
   input  logic [2*NUM_CH-1:0]     ev_sev_i,
   input  logic [2*NUM_CH-1:0]     ev_act_i,
   input  logic [MSG_W*NUM_CH-1:0] ev_msg_i,
   input  logic [1:0]              sev_thr_i,
   input  logic                    clr_i,
   output logic                    log_valid_o,
   input  logic                    log_ready_i,
   output logic [TS_W+$clog2(NUM_CH)+2+MSG_W-1:0] log_data_o,
   output logic [CNT_W-1:0]        info_cnt_o,
   output logic [CNT_W-1:0]        warn_cnt_o,
   output logic [CNT_W-1:0]        err_cnt_o,
   output logic [CNT_W-1:0]        fatal_cnt_o,
   output logic [CNT_W-1:0]        drop_cnt_o,
   output logic                    stop_o,
   output logic                    exit_o,
   output logic                    full_o
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int AW    = $clog2(DEPTH);
   localparam int LOG_W = TS_W + CH_W + 2 + MSG_W;

   logic [TS_W-1:0]  ts_q;
   logic [CH_W-1:0]  last_q;
   logic [CH_W-1:0]  sel;
   logic [CH_W:0]    cand;
   logic             found;
   logic             accept;
   logic [1:0]       sel_type;
   logic [1:0]       sel_sev;
   logic [1:0]       sel_act;
   logic [MSG_W-1:0] sel_msg;
   logic             filt_in;
   logic             push;
   logic             pop;
   logic             drop;
   logic [3:0]       type_inc;

   logic [LOG_W-1:0] mem [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;

   // Search begins one past the last granted channel and wraps.
   always_comb begin
      found = 1'b0;
      sel   = last_q;
      cand  = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = {1'b0, last_q} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH))
            cand = cand - (CH_W+1)'(NUM_CH);
         if (!found && ev_valid_i[cand[CH_W-1:0]]) begin
            found = 1'b1;
            sel   = cand[CH_W-1:0];
         end
      end
   end

   assign accept     = found & ~stop_o & ~exit_o & ~rst_i;
   assign ev_ready_o = accept ? (NUM_CH'(1) << sel) : '0;

   assign sel_type = ev_type_i[2*int'(sel) +: 2];
   assign sel_sev  = ev_sev_i[2*int'(sel) +: 2];
   assign sel_act  = ev_act_i[2*int'(sel) +: 2];
   assign sel_msg  = ev_msg_i[MSG_W*int'(sel) +: MSG_W];

   assign filt_in  = accept & (sel_sev >= sev_thr_i);
   assign pop      = log_valid_o & log_ready_i;
   assign push     = filt_in & (~full_o | pop);
   assign drop     = filt_in & full_o & ~pop;
   assign type_inc = accept ? (4'(1) << sel_type) : 4'b0;

   assign log_valid_o = (wr_q != rd_q);
   assign full_o      = (wr_q[AW] != rd_q[AW]) &&
                        (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign log_data_o  = mem[rd_q[AW-1:0]];

   function automatic logic [CNT_W-1:0] bump(
      input logic [CNT_W-1:0] v,
      input logic             en
   );
      return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
   endfunction

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_q[AW-1:0]] <= {ts_q, sel, sel_type, sel_msg};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_q        <= '0;
         last_q      <= CH_W'(NUM_CH - 1);
         wr_q        <= '0;
         rd_q        <= '0;
         info_cnt_o  <= '0;
         warn_cnt_o  <= '0;
         err_cnt_o   <= '0;
         fatal_cnt_o <= '0;
         drop_cnt_o  <= '0;
         stop_o      <= 1'b0;
         exit_o      <= 1'b0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (accept)
            last_q <= sel;
         if (push)
            wr_q <= wr_q + (AW+1)'(1);
         if (pop)
            rd_q <= rd_q + (AW+1)'(1);
         // A clear zeroes first, so a same-cycle event lands on zero.
         info_cnt_o  <= bump(clr_i ? '0 : info_cnt_o,  type_inc[0]);
         warn_cnt_o  <= bump(clr_i ? '0 : warn_cnt_o,  type_inc[1]);
         err_cnt_o   <= bump(clr_i ? '0 : err_cnt_o,   type_inc[2]);
         fatal_cnt_o <= bump(clr_i ? '0 : fatal_cnt_o, type_inc[3]);
         drop_cnt_o  <= bump(clr_i ? '0 : drop_cnt_o,  drop);
         stop_o <= (stop_o & ~clr_i) | (filt_in & (sel_act == 2'd1));
         exit_o <= exit_o | (filt_in & (sel_act == 2'd2));
      end
   end

endmodule

// File: tb/tb_rpt_event_logger.sv
// Scoreboard bench for rpt_event_logger: directed events, queued
// expected log entries, and a monitor that checks every pop.
module tb_rpt_event_logger;

   localparam int NUM_CH = 4;
   localparam int MSG_W  = 16;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 4;
   localparam int TS_W   = 16;
   localparam int LOG_W  = TS_W + 2 + 2 + MSG_W;

   logic                    clk_i = 1'b0;
   logic                    rst_i = 1'b1;
   logic [NUM_CH-1:0]       ev_valid_i;
   logic [NUM_CH-1:0]       ev_ready_o;
   logic [2*NUM_CH-1:0]     ev_type_i;
   logic [2*NUM_CH-1:0]     ev_sev_i;
   logic [2*NUM_CH-1:0]     ev_act_i;
   logic [MSG_W*NUM_CH-1:0] ev_msg_i;
   logic [1:0]              sev_thr_i = 2'd0;
   logic                    clr_i = 1'b0;
   logic                    log_valid_o;
   logic                    log_ready_i = 1'b0;
   logic [LOG_W-1:0]        log_data_o;
   logic [CNT_W-1:0]        info_cnt_o, warn_cnt_o, err_cnt_o;
   logic [CNT_W-1:0]        fatal_cnt_o, drop_cnt_o;
   logic                    stop_o, exit_o, full_o;

   logic [1:0]  typ [NUM_CH];
   logic [1:0]  sev [NUM_CH];
   logic [1:0]  act [NUM_CH];
   logic [15:0] msg [NUM_CH];
   logic [NUM_CH-1:0] vld = '0;

   logic [TS_W-1:0]  tb_ts = '0;
   logic [LOG_W-1:0] exp_q [$];
   int n_cmp = 0;
   int n_bad = 0;

   assign ev_valid_i = vld;
   assign ev_type_i  = {typ[3], typ[2], typ[1], typ[0]};
   assign ev_sev_i   = {sev[3], sev[2], sev[1], sev[0]};
   assign ev_act_i   = {act[3], act[2], act[1], act[0]};
   assign ev_msg_i   = {msg[3], msg[2], msg[1], msg[0]};

   rpt_event_logger #(
      .NUM_CH(NUM_CH), .MSG_W(MSG_W), .DEPTH(DEPTH),
      .CNT_W(CNT_W), .TS_W(TS_W)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ev_valid_i(ev_valid_i), .ev_ready_o(ev_ready_o),
      .ev_type_i(ev_type_i), .ev_sev_i(ev_sev_i),
      .ev_act_i(ev_act_i), .ev_msg_i(ev_msg_i),
      .sev_thr_i(sev_thr_i), .clr_i(clr_i),
      .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
      .log_data_o(log_data_o),
      .info_cnt_o(info_cnt_o), .warn_cnt_o(warn_cnt_o),
      .err_cnt_o(err_cnt_o), .fatal_cnt_o(fatal_cnt_o),
      .drop_cnt_o(drop_cnt_o),
      .stop_o(stop_o), .exit_o(exit_o), .full_o(full_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference cycle count, used as the expected timestamp.
   always @(posedge clk_i)
      tb_ts <= rst_i ? '0 : tb_ts + TS_W'(1);

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   always @(negedge clk_i) begin
      if (!rst_i && log_valid_o && log_ready_i) begin
         logic [LOG_W-1:0] e;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL log_extra: got %0h want none", log_data_o);
         end else begin
            e = exp_q.pop_front();
            chk("log_entry", 64'(log_data_o), 64'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ev(input int c, input logic v, input logic [1:0] t,
                         input logic [1:0] s, input logic [1:0] a,
                         input logic [15:0] m);
      vld[c] = v;
      typ[c] = t;
      sev[c] = s;
      act[c] = a;
      msg[c] = m;
   endtask

   task automatic step(input logic [3:0] exp_rdy, input bit exp_push);
      int c;
      #1;
      chk("ready", 64'(ev_ready_o), 64'(exp_rdy));
      c = 0;
      for (int i = 0; i < NUM_CH; i++)
         if (exp_rdy[i]) c = i;
      if (exp_push)
         exp_q.push_back({tb_ts, 2'(c), typ[c], msg[c]});
      tick();
   endtask

   task automatic drain(input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() != 0; i++)
         tick();
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_clr();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      for (int c = 0; c < NUM_CH; c++)
         set_ev(c, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0);
      repeat (3) tick();
      chk("rst_ready", 64'(ev_ready_o), 64'd0);
      chk("rst_flags", {log_valid_o, full_o, stop_o, exit_o}, 64'd0);
      chk("rst_cnts", {info_cnt_o, warn_cnt_o, err_cnt_o,
                       fatal_cnt_o, drop_cnt_o}, 64'd0);

      // Round-robin with every channel requesting
      for (int c = 0; c < NUM_CH; c++)
         set_ev(c, 1'b1, 2'd0, 2'd0, 2'd0, 16'hA000 + 16'(c));
      log_ready_i = 1'b1;
      rst_i = 1'b0;
      step(4'b0001, 1);
      step(4'b0010, 1);
      step(4'b0100, 1);
      step(4'b1000, 1);
      step(4'b0001, 1);
      vld = '0;
      chk("rr_info", 64'(info_cnt_o), 64'd5);
      drain(20);
      pulse_clr();
      chk("clr_cnts", {info_cnt_o, warn_cnt_o, err_cnt_o,
                       fatal_cnt_o, drop_cnt_o}, 64'd0);

      // Severity filter
      sev_thr_i = 2'd2;
      set_ev(1, 1'b1, 2'd0, 2'd1, 2'd0, 16'hB001);
      step(4'b0010, 0);
      vld = '0;
      set_ev(2, 1'b1, 2'd2, 2'd3, 2'd0, 16'hB002);
      step(4'b0100, 1);
      vld = '0;
      tick();
      chk("flt_info", 64'(info_cnt_o), 64'd1);
      chk("flt_err", 64'(err_cnt_o), 64'd1);
      drain(20);

      // Overflow: 10 events into an 8-deep FIFO with no drain
      sev_thr_i = 2'd0;
      log_ready_i = 1'b0;
      pulse_clr();
      for (int i = 0; i < 10; i++) begin
         set_ev(0, 1'b1, 2'd1, 2'd1, 2'd0, 16'hC000 + 16'(i));
         step(4'b0001, i < DEPTH);
      end
      vld = '0;
      chk("ovf_full", 64'(full_o), 64'd1);
      chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
      chk("ovf_warn", 64'(warn_cnt_o), 64'd10);
      log_ready_i = 1'b1;
      drain(20);
      chk("ovf_empty", {full_o, log_valid_o}, 64'd0);

      // STOP halts intake until clear
      pulse_clr();
      set_ev(1, 1'b1, 2'd3, 2'd3, 2'd1, 16'hD001);
      step(4'b0010, 1);
      vld = '0;
      set_ev(2, 1'b1, 2'd0, 2'd0, 2'd0, 16'hD002);
      #1;
      chk("stop_set", 64'(stop_o), 64'd1);
      chk("stop_ready", 64'(ev_ready_o), 64'd0);
      chk("stop_fatal", 64'(fatal_cnt_o), 64'd1);
      tick();
      tick();
      chk("stop_hold", 64'(ev_ready_o), 64'd0);
      pulse_clr();
      chk("stop_clr", 64'(stop_o), 64'd0);
      chk("stop_clr_cnt", {info_cnt_o, fatal_cnt_o}, 64'd0);
      step(4'b0100, 1);
      vld = '0;
      chk("resume_info", 64'(info_cnt_o), 64'd1);
      drain(20);

      // EXIT survives clear; reset also discards the queued entry
      log_ready_i = 1'b0;
      set_ev(3, 1'b1, 2'd2, 2'd2, 2'd2, 16'hE003);
      step(4'b1000, 1);
      vld = '0;
      set_ev(0, 1'b1, 2'd0, 2'd0, 2'd0, 16'hE000);
      #1;
      chk("exit_set", 64'(exit_o), 64'd1);
      chk("exit_ready", 64'(ev_ready_o), 64'd0);
      tick();
      pulse_clr();
      chk("exit_after_clr", 64'(exit_o), 64'd1);
      chk("clr_keeps_fifo", 64'(log_valid_o), 64'd1);
      rst_i = 1'b1;
      tick();
      chk("exit_rst", 64'(exit_o), 64'd0);
      chk("rst_fifo", {log_valid_o, full_o}, 64'd0);
      chk("rst_ready2", 64'(ev_ready_o), 64'd0);
      exp_q.delete();
      vld = '0;
      rst_i = 1'b0;

      // Counter saturation; action 3 behaves as LOG
      log_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_ev(0, 1'b1, 2'd1, 2'd0, 2'd3, 16'hF000 + 16'(i));
         step(4'b0001, 1);
      end
      vld = '0;
      chk("sat_warn", 64'(warn_cnt_o), 64'd15);
      chk("sat_drop", 64'(drop_cnt_o), 64'd0);
      chk("act3_no_stop", {stop_o, exit_o}, 64'd0);
      drain(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
